// File: rtl/banked_sram_ctrl.sv
// Banked SRAM with lane-masked writes, in-order tagged read responses through a
// credit-limited FIFO, and an optional fill sweep after reset.
module banked_sram_ctrl #(
    parameter int unsigned     ADDRESS    = 9,
    parameter int unsigned     BANK_BITS  = 2,
    parameter int unsigned     DATA       = 32,
    parameter int unsigned     LANE_W     = 8,
    parameter int unsigned     ID_W       = 4,
    parameter int unsigned     RSP_DEPTH  = 4,
    parameter bit              INIT_EN    = 1'b1,
    parameter logic [DATA-1:0] INIT_VALUE = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [ADDRESS-1:0]       i_req_address,
    input  logic [DATA-1:0]          i_req_wdata,
    input  logic [DATA/LANE_W-1:0]   i_req_wmask,
    input  logic [ID_W-1:0]          i_req_id,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA-1:0]          o_rsp_data,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic                     o_init_done
);
    localparam int unsigned NUM_BANKS = 1 << BANK_BITS;
    localparam int unsigned ROW_BITS  = ADDRESS - BANK_BITS;
    localparam int unsigned ROWS      = 1 << ROW_BITS;
    localparam int unsigned LANES     = DATA / LANE_W;
    localparam int unsigned PTR_W     = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    typedef enum logic {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] row_cnt_q, row_cnt_d;

    logic [BANK_BITS-1:0] req_bank;
    logic [ROW_BITS-1:0]  req_row;
    logic                 req_fire;
    logic                 rd_fire;

    logic [ROW_BITS-1:0]  bank_row;
    logic [DATA-1:0]      bank_wdata;
    logic [LANES-1:0]     bank_wmask;
    logic [NUM_BANKS-1:0] bank_we;
    logic [NUM_BANKS-1:0] bank_re;
    logic [NUM_BANKS-1:0][DATA-1:0] bank_rdata;

    logic                 inflight_q;
    logic [BANK_BITS-1:0] rd_bank_q;
    logic [ID_W-1:0]      rd_id_q;

    logic [DATA-1:0]  fifo_data [RSP_DEPTH];
    logic [ID_W-1:0]  fifo_id   [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] used;
    logic             fifo_push, fifo_pop, fifo_empty;
    logic [DATA-1:0]  last_data_q;
    logic [ID_W-1:0]  last_id_q;

    assign req_bank = i_req_address[BANK_BITS-1:0];
    assign req_row  = i_req_address[ADDRESS-1:BANK_BITS];

    // Credits cover both queued entries and the read still in the bank register.
    assign used        = count_q + CNT_W'(inflight_q);
    assign o_req_ready = (state_q == StRun) && (used < CNT_W'(RSP_DEPTH));
    assign o_init_done = (state_q == StRun);
    assign req_fire    = i_rst_n && i_req_valid && o_req_ready;
    assign rd_fire     = req_fire && !i_req_write;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StInit;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        unique case (state_q)
            StInit: begin
                if (!INIT_EN || row_cnt_q == {ROW_BITS{1'b1}}) begin
                    state_d = StRun;
                end else begin
                    row_cnt_d = row_cnt_q + ROW_BITS'(1);
                end
            end
            StRun: state_d = StRun;
        endcase
    end

    always_comb begin
        bank_row   = req_row;
        bank_wdata = i_req_wdata;
        bank_wmask = i_req_wmask;
        bank_we    = '0;
        bank_re    = '0;
        if (state_q == StInit) begin
            bank_row   = row_cnt_q;
            bank_wdata = INIT_VALUE;
            bank_wmask = '1;
            bank_we    = {NUM_BANKS{INIT_EN}};
        end else if (req_fire) begin
            if (i_req_write) begin
                bank_we[req_bank] = 1'b1;
            end else begin
                bank_re[req_bank] = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA-1:0] mem [ROWS];
        logic [DATA-1:0] rdata_q;

        always_ff @(posedge i_clk) begin
            if (bank_we[b]) begin
                for (int k = 0; k < LANES; k++) begin
                    if (bank_wmask[k]) begin
                        mem[bank_row][k*LANE_W +: LANE_W] <= bank_wdata[k*LANE_W +: LANE_W];
                    end
                end
            end
            if (bank_re[b]) begin
                rdata_q <= mem[bank_row];
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            inflight_q <= 1'b0;
            rd_bank_q  <= '0;
            rd_id_q    <= '0;
        end else begin
            inflight_q <= rd_fire;
            if (rd_fire) begin
                rd_bank_q <= req_bank;
                rd_id_q   <= i_req_id;
            end
        end
    end

    assign fifo_push  = inflight_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_pop   = !fifo_empty && i_rsp_ready;

    always_comb begin
        count_d = count_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr_q] <= bank_rdata[rd_bank_q];
            fifo_id[wr_ptr_q]   <= rd_id_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_data_q <= '0;
            last_id_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(fifo_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(fifo_pop);
            count_q  <= count_d;
            if (fifo_pop) begin
                last_data_q <= fifo_data[rd_ptr_q];
                last_id_q   <= fifo_id[rd_ptr_q];
            end
        end
    end

    // Once drained, the outputs keep showing the last popped entry.
    assign o_rsp_valid = !fifo_empty;
    assign o_rsp_data  = fifo_empty ? last_data_q : fifo_data[rd_ptr_q];
    assign o_rsp_id    = fifo_empty ? last_id_q : fifo_id[rd_ptr_q];

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(fifo_push && !fifo_pop && count_q == CNT_W'(RSP_DEPTH)))
                else $error("response fifo overflow");
        end
    end
`endif

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// Randomised and directed bench for banked_sram_ctrl, checked against a
// transaction-level model: flat word array plus a queue of pending responses.
module tb_banked_sram_ctrl;
    localparam int DEPTH = 4;
    localparam int ROWS  = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, rsp_ready;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask, req_id;
    logic        o_req_ready, o_rsp_valid, o_init_done;
    logic [31:0] o_rsp_data;
    logic [3:0]  o_rsp_id;

    always #5 clk = ~clk;

    banked_sram_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_write   (req_write),
        .i_req_address (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_wmask   (req_wmask),
        .i_req_id      (req_id),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_id      (o_rsp_id),
        .o_init_done   (o_init_done)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        longint      due;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem [512];
    logic [31:0] last_data;
    logic [3:0]  last_id;
    int          compared = 0;
    int          mismatched = 0;
    bit          model_ok = 1'b0;
    int          init_left = 0;
    longint      cyc = 0;
    bit          exp_ready, exp_valid, last_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_data;
        logic [3:0]  e_id;
        if (!model_ok) return;
        exp_ready = (init_left == 0) && (exp_q.size() < DEPTH);
        exp_valid = 1'b0;
        e_data = last_data;
        e_id   = last_id;
        if (exp_q.size() > 0) begin
            if (exp_q[0].due <= cyc) begin
                exp_valid = 1'b1;
                e_data    = exp_q[0].data;
                e_id      = exp_q[0].id;
            end
        end
        check_eq("req_ready", o_req_ready, exp_ready);
        check_eq("init_done", o_init_done, init_left == 0);
        check_eq("rsp_valid", o_rsp_valid, exp_valid);
        check_eq("rsp_data", o_rsp_data, e_data);
        check_eq("rsp_id", o_rsp_id, e_id);
    endtask

    task automatic update_model();
        last_acc = 1'b0;
        if (!rst_n) begin
            model_ok  = 1'b1;
            init_left = ROWS;
            exp_q.delete();
            last_data = '0;
            last_id   = '0;
        end else if (model_ok) begin
            if (init_left > 0) begin
                init_left--;
                if (init_left == 0) foreach (ref_mem[i]) ref_mem[i] = '0;
            end else begin
                if (exp_valid && rsp_ready) begin
                    last_data = exp_q[0].data;
                    last_id   = exp_q[0].id;
                    void'(exp_q.pop_front());
                end
                if (req_valid && exp_ready) begin
                    last_acc = 1'b1;
                    if (req_write) begin
                        for (int k = 0; k < 4; k++)
                            if (req_wmask[k]) ref_mem[req_addr][k*8 +: 8] = req_wdata[k*8 +: 8];
                    end else begin
                        exp_q.push_back('{req_id, ref_mem[req_addr], cyc + 2});
                    end
                end
            end
        end
        cyc++;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        check_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic req(input bit wr, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [3:0] id);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        req_id    = id;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        check_eq("req_accept", last_acc, 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!o_init_done && n < 300) begin
            tick();
            n++;
        end
        check_eq("init_cycles", n, ROWS);
    endtask

    // Expects an empty response path on entry.
    task automatic read_direct(input logic [8:0] a, input logic [3:0] id, input logic [31:0] d);
        req(1'b0, a, '0, '0, id);
        check_eq("lat_valid_early", o_rsp_valid, 0);
        tick();
        check_eq("lat_valid", o_rsp_valid, 1);
        check_eq("direct_data", o_rsp_data, d);
        check_eq("direct_id", o_rsp_id, id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; req_id = '0; rsp_ready = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_init();

        read_direct(9'h1FF, 4'd1, 32'h0000_0000);
        idle(2);

        req(1'b1, 9'h005, 32'hDEAD_BEEF, 4'hF, 4'd0);
        req(1'b1, 9'h005, 32'h1122_3344, 4'b0101, 4'd0);
        read_direct(9'h005, 4'd3, 32'hDE22_BE44);
        idle(2);

        for (int i = 0; i < 4; i++) req(1'b1, 9'(4 + i), 32'hA5A5_0000 + 32'(i * 17), 4'hF, 4'd0);
        for (int i = 0; i < 4; i++) req(1'b0, 9'(4 + i), '0, '0, 4'(i));
        idle(4);

        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) req(1'b0, 9'(4 + i), '0, '0, 4'(8 + i));
        check_eq("bp_ready_low", o_req_ready, 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h006; req_id = 4'd12;
        repeat (3) begin
            tick();
            check_eq("bp_no_accept", last_acc, 0);
        end
        rsp_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        check_eq("bp_accept5", last_acc, 1);
        req(1'b0, 9'h007, '0, '0, 4'd13);
        idle(8);

        req(1'b1, 9'h0A0, 32'hCAFE_F00D, 4'hF, 4'd0);
        req(1'b0, 9'h0A0, '0, '0, 4'd7);
        for (int i = 0; i < 8; i++) req(1'b0, 9'(4 + (i % 4)), '0, '0, 4'(i));
        idle(6);

        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) req(1'b0, 9'(4 + i), '0, '0, 4'(i));
        idle(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_rsp_valid", o_rsp_valid, 0);
        rsp_ready = 1'b1;
        wait_init();
        idle(5);

        for (int i = 0; i < 900; i++) begin
            rst_n     = (i != 450);
            req_valid = ($urandom_range(0, 9) < 6);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_wmask = 4'($urandom);
            req_id    = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/banked_sram_ctrl.md
Name: banked_sram_ctrl

Overview:
- Parametrised multi-bank SRAM with masked writes, a tagged read-response path and a post-reset initialisation sweep.
- Replaces bare per-bank instances in the cache data/tag arrays.
- Requests enter on a valid/ready port. Address low bits select the bank and high bits select the row.
- Read data returns in order through a credit-limited response FIFO, so downstream backpressure never drops data.

Parameters:
- ADDRESS, 9, total word-address width (bank bits + row bits)
- BANK_BITS, 2, log2 of bank count; NUM_BANKS = 1<<BANK_BITS; ROW_BITS = ADDRESS-BANK_BITS (must be >= 1)
- DATA, 32, word width; must be a multiple of LANE_W
- LANE_W, 8, write-mask granularity; LANES = DATA/LANE_W
- ID_W, 4, request tag width
- RSP_DEPTH, 4, response FIFO depth (power of two, >= 2)
- INIT_EN, 1, 1 = zero-fill every word after reset; 0 = skip
- INIT_VALUE, 0, DATA-wide fill value

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid&&ready
- i_req_write  in  1  1 = write, 0 = read
- i_req_address  in  ADDRESS  word address; [BANK_BITS-1:0] = bank, upper bits = row
- i_req_wdata  in  DATA  write data
- i_req_wmask  in  LANES  per-lane write enable
- i_req_id  in  ID_W  tag returned with read data
- o_rsp_valid  out  1  read response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_data  out  DATA  read data
- o_rsp_id  out  ID_W  tag of that read
- o_init_done  out  1  high once the array is usable

Behaviour:
- Reset (i_rst_n=0 at edge): o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_init_done=0.
  - FIFO emptied, in-flight read dropped, state goes to INIT (or RUN if INIT_EN=0).
  - Array contents are not reset.
  - A reset mid-sweep or mid-traffic behaves identically.
- FSM states: INIT and RUN.
  - INIT: row counter runs 0..2^ROW_BITS-1, one row per cycle. All banks and all lanes write INIT_VALUE at that row.
  - INIT takes exactly 2^ROW_BITS cycles; the cycle after the last row write, the state becomes RUN and o_init_done=1.
  - With INIT_EN=0, RUN and o_init_done=1 are reached on the first cycle after reset deasserts.
- o_req_ready = RUN && (fifo_count + inflight) < RSP_DEPTH.
  - Computed from registered state only; no combinational path from i_rsp_ready or i_req_valid.
  - The credit check gates writes too.
- Write accept: only the addressed bank is enabled. Lane k is updated iff i_req_wmask[k]; wmask=0 is a legal no-op. No response is produced.
- Read accept at cycle N:
  - Addressed bank registers mem[row] at edge N+1; inflight=1 during N+1.
  - The word and tag are pushed into the FIFO at edge N+2 (so o_rsp_valid rises at cycle N+2 when the FIFO was empty).
  - Back-to-back reads are accepted at one per cycle while credits remain.
- Read-after-write to the same address in consecutive cycles returns the new data (write committed before the read samples).
- FIFO:
  - Show-ahead: o_rsp_data/o_rsp_id are the head entry, and o_rsp_valid = !empty.
  - Pop on o_rsp_valid&&i_rsp_ready. A push and a pop in the same cycle is legal, and the count is unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - The credit rule guarantees no push when full; an overflow is an assertion failure.
- Output hold: o_rsp_data/o_rsp_id are stable while o_rsp_valid=1 and i_rsp_ready=0.
  - After the last pop they hold their last value; they are not X.
- Request fields are ignored when i_req_valid=0 or o_req_ready=0.

Test Plan:
- INIT_EN=1, ADDRESS=9, BANK_BITS=2: release reset -> o_init_done and o_req_ready rise exactly 128 cycles later; a read of address 0x1FF returns 0x00000000.
- Write 0xDEADBEEF to address 0x005, then write 0x11223344 with wmask=4'b0101 to the same address, then read with id 3 -> o_rsp_data=0xDE22BE44, o_rsp_id=3, o_rsp_valid exactly 2 cycles after the read accept.
- Write distinct values to 0x004/0x005/0x006/0x007 (same row, banks 0..3) and read back in order with ids 0..3 -> each bank returns its own value in tag order; no cross-bank corruption.
- Hold i_rsp_ready=0 and issue 6 back-to-back reads (RSP_DEPTH=4):
  - o_req_ready drops after the 4th accept and the FIFO holds 4 entries with a stable head.
  - Raising i_rsp_ready drains in order, and ready reasserts the cycle after the first pop.
- Write then immediately read address 0x0A0 in consecutive cycles -> the new data is returned; with continuous i_rsp_ready=1, reads stream at 1 per cycle with constant 2-cycle latency.
- Assert i_rst_n=0 for one cycle while 3 responses are queued and the sweep is idle -> o_rsp_valid=0 next cycle, the INIT sweep restarts, and no stale response appears afterwards.
